// File: rtl/axis_pkt_limiter_if.sv
// AXI-Stream beat bundle shared by the limiter's input and output sides.
// master drives data/last/valid and samples ready; slave is the mirror image.
interface axis_pkt_limiter_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_pkt_limiter.sv
// Caps forwarded AXI-Stream packets at MAX_PKT_SIZE beats, forcing tlast on a cut and dropping the rest.
// 1-cycle latency via output + skid register; s_axis_tready drops only once the skid register holds a beat.
module axis_pkt_limiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_PKT_SIZE = 128,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    axis_pkt_limiter_if.slave    s_axis,
    axis_pkt_limiter_if.master   m_axis,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic [CNT_WIDTH-1:0] trunc_count,
    output logic                 trunc_pulse
);

    localparam int            CW       = $clog2(MAX_PKT_SIZE + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(MAX_PKT_SIZE - 1);

    typedef enum logic {
        PASS,
        DROP
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         beat_cnt;
    logic [CW-1:0]         beat_cnt_nxt;
    logic                  ready_en;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  fwd_last;
    logic                  close_pkt;
    logic                  trunc;

    logic                  out_vld;
    logic [DATA_WIDTH-1:0] out_dat;
    logic                  out_last;
    logic                  skid_vld;
    logic [DATA_WIDTH-1:0] skid_dat;
    logic                  skid_last;

    // ready_en holds input ready low from reset release until the first clock edge
    assign s_axis.tready = ready_en && ((state == DROP) || !skid_vld);
    assign accept        = s_axis.tvalid && s_axis.tready;
    assign pop           = out_vld && m_axis.tready;

    assign m_axis.tvalid = out_vld;
    assign m_axis.tdata  = out_dat;
    assign m_axis.tlast  = out_last;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state    <= PASS;
            beat_cnt <= '0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        push         = 1'b0;
        fwd_last     = s_axis.tlast;
        close_pkt    = 1'b0;
        trunc        = 1'b0;
        case (state)
            PASS: begin
                if (accept) begin
                    push = 1'b1;
                    if (s_axis.tlast) begin
                        beat_cnt_nxt = '0;
                        close_pkt    = 1'b1;
                    end else if (beat_cnt == LAST_IDX) begin
                        fwd_last     = 1'b1;
                        beat_cnt_nxt = '0;
                        close_pkt    = 1'b1;
                        trunc        = 1'b1;
                        state_nxt    = DROP;
                    end else begin
                        beat_cnt_nxt = beat_cnt + CW'(1);
                    end
                end
            end
            DROP: begin
                if (accept && s_axis.tlast) begin
                    state_nxt = PASS;
                end
            end
        endcase
    end

    // In PASS a push only happens with the skid register empty, so push and skid_vld never coincide.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            out_vld   <= 1'b0;
            out_dat   <= '0;
            out_last  <= 1'b0;
            skid_vld  <= 1'b0;
            skid_dat  <= '0;
            skid_last <= 1'b0;
        end else if (!out_vld || pop) begin
            if (skid_vld) begin
                out_vld  <= 1'b1;
                out_dat  <= skid_dat;
                out_last <= skid_last;
                skid_vld <= 1'b0;
            end else if (push) begin
                out_vld  <= 1'b1;
                out_dat  <= s_axis.tdata;
                out_last <= fwd_last;
            end else begin
                out_vld  <= 1'b0;
            end
        end else if (push) begin
            skid_vld  <= 1'b1;
            skid_dat  <= s_axis.tdata;
            skid_last <= fwd_last;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pkt_count   <= '0;
            trunc_count <= '0;
            trunc_pulse <= 1'b0;
        end else begin
            trunc_pulse <= trunc;
            if (close_pkt && (pkt_count != '1)) begin
                pkt_count <= pkt_count + CNT_WIDTH'(1);
            end
            if (trunc && (trunc_count != '1)) begin
                trunc_count <= trunc_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_pkt_limiter.sv
// Drives two limiters (MAX_PKT_SIZE=4/CNT_WIDTH=16 and MAX_PKT_SIZE=1/CNT_WIDTH=2) and
// checks every cycle against a packet-position model of the truncation rules.
module tb_axis_pkt_limiter;
    localparam int DW = 32;

    logic aclk   = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    axis_pkt_limiter_if #(.DATA_WIDTH(DW)) sa ();
    axis_pkt_limiter_if #(.DATA_WIDTH(DW)) ma ();
    axis_pkt_limiter_if #(.DATA_WIDTH(DW)) sb ();
    axis_pkt_limiter_if #(.DATA_WIDTH(DW)) mb ();

    logic          s_vld  [2];
    logic          s_last [2];
    logic [DW-1:0] s_dat  [2];
    logic          m_rdy  [2];
    logic          o_srdy [2];
    logic          o_mvld [2];
    logic          o_mlast[2];
    logic          o_pulse[2];
    logic [DW-1:0] o_mdat [2];
    logic [15:0]   o_pkt  [2];
    logic [15:0]   o_trc  [2];
    logic [1:0]    pkt_b;
    logic [1:0]    trc_b;

    assign sa.tvalid = s_vld[0];
    assign sa.tlast  = s_last[0];
    assign sa.tdata  = s_dat[0];
    assign ma.tready = m_rdy[0];
    assign sb.tvalid = s_vld[1];
    assign sb.tlast  = s_last[1];
    assign sb.tdata  = s_dat[1];
    assign mb.tready = m_rdy[1];

    assign o_srdy[0]  = sa.tready;
    assign o_mvld[0]  = ma.tvalid;
    assign o_mlast[0] = ma.tlast;
    assign o_mdat[0]  = ma.tdata;
    assign o_srdy[1]  = sb.tready;
    assign o_mvld[1]  = mb.tvalid;
    assign o_mlast[1] = mb.tlast;
    assign o_mdat[1]  = mb.tdata;
    assign o_pkt[1]   = {14'd0, pkt_b};
    assign o_trc[1]   = {14'd0, trc_b};

    axis_pkt_limiter #(.DATA_WIDTH(DW), .MAX_PKT_SIZE(4), .CNT_WIDTH(16)) dut_a (
        .aclk        (aclk),
        .areset      (areset),
        .s_axis      (sa),
        .m_axis      (ma),
        .pkt_count   (o_pkt[0]),
        .trunc_count (o_trc[0]),
        .trunc_pulse (o_pulse[0])
    );

    axis_pkt_limiter #(.DATA_WIDTH(DW), .MAX_PKT_SIZE(1), .CNT_WIDTH(2)) dut_b (
        .aclk        (aclk),
        .areset      (areset),
        .s_axis      (sb),
        .m_axis      (mb),
        .pkt_count   (pkt_b),
        .trunc_count (trc_b),
        .trunc_pulse (o_pulse[1])
    );

    // Reference model: pos = beats of the current source packet seen so far
    logic [32:0] src [2][$];
    logic [32:0] expq[2][$];
    int          occ    [2];
    int          pos    [2];
    int          m_pk   [2];
    int          m_tr   [2];
    logic        m_pulse[2];
    logic        armed  [2];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int rdy_mode    = 0;
    int rdy_until   = 0;
    bit rnd_valid   = 1'b0;

    function automatic int maxp(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int satv(input int d);
        return (d == 0) ? 65535 : 3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int d, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            src[d].push_back({(i == n - 1), base + 32'(i)});
        end
    endtask

    task automatic step();
        logic        exp_rdy;
        logic        acc;
        logic        popm;
        logic        lst;
        logic        cut;
        logic [32:0] b;
        @(negedge aclk);
        for (int d = 0; d < 2; d++) begin
            s_vld[d] = (src[d].size() > 0) && (!rnd_valid || ($urandom_range(0, 4) != 0));
            if (s_vld[d]) b = src[d][0];
            else          b = 33'h0;
            s_last[d] = b[32];
            s_dat[d]  = b[31:0];
            case (rdy_mode)
                0:       m_rdy[d] = 1'b1;
                1:       m_rdy[d] = 1'($urandom_range(0, 1));
                default: m_rdy[d] = (cyc < rdy_until);
            endcase
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_rdy = armed[d] && ((pos[d] >= maxp(d)) || (occ[d] < 2));
            chk($sformatf("s_tready%0d", d), 64'(o_srdy[d]), 64'(exp_rdy));
            chk($sformatf("m_tvalid%0d", d), 64'(o_mvld[d]), 64'(occ[d] > 0));
            if (occ[d] > 0) begin
                b = expq[d][0];
                chk($sformatf("m_tdata%0d", d), 64'(o_mdat[d]), 64'(b[31:0]));
                chk($sformatf("m_tlast%0d", d), 64'(o_mlast[d]), 64'(b[32]));
            end
            popm = (occ[d] > 0) && m_rdy[d];
            acc  = s_vld[d] && exp_rdy;
            if (popm) begin
                void'(expq[d].pop_front());
                occ[d]--;
            end
            cut = 1'b0;
            if (acc) begin
                b   = src[d].pop_front();
                lst = b[32];
                if (pos[d] < maxp(d)) begin
                    cut = !lst && (pos[d] == maxp(d) - 1);
                    expq[d].push_back({lst || cut, b[31:0]});
                    occ[d]++;
                    if ((lst || cut) && m_pk[d] < satv(d)) m_pk[d]++;
                    if (cut && m_tr[d] < satv(d)) m_tr[d]++;
                end
                pos[d] = lst ? 0 : pos[d] + 1;
            end
            m_pulse[d] = cut;
        end
        @(posedge aclk);
        #1;
        for (int d = 0; d < 2; d++) begin
            armed[d] = 1'b1;
            chk($sformatf("pkt_count%0d", d), 64'(o_pkt[d]), 64'(m_pk[d]));
            chk($sformatf("trunc_count%0d", d), 64'(o_trc[d]), 64'(m_tr[d]));
            chk($sformatf("trunc_pulse%0d", d), 64'(o_pulse[d]), 64'(m_pulse[d]));
        end
        cyc++;
    endtask

    task automatic check_zero();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_s_tready%0d", d), 64'(o_srdy[d]), 64'(0));
            chk($sformatf("rst_m_tvalid%0d", d), 64'(o_mvld[d]), 64'(0));
            chk($sformatf("rst_m_tdata%0d", d), 64'(o_mdat[d]), 64'(0));
            chk($sformatf("rst_m_tlast%0d", d), 64'(o_mlast[d]), 64'(0));
            chk($sformatf("rst_pkt%0d", d), 64'(o_pkt[d]), 64'(0));
            chk($sformatf("rst_trunc%0d", d), 64'(o_trc[d]), 64'(0));
            chk($sformatf("rst_pulse%0d", d), 64'(o_pulse[d]), 64'(0));
        end
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            s_vld[d] = 1'b0;
            src[d].delete();
            expq[d].delete();
            occ[d]     = 0;
            pos[d]     = 0;
            m_pk[d]    = 0;
            m_tr[d]    = 0;
            m_pulse[d] = 1'b0;
            armed[d]   = 1'b0;
        end
        repeat (2) begin
            @(posedge aclk);
            #1;
            check_zero();
        end
        #2;
        areset = 1'b0;
        #1;
        check_zero();
    endtask

    task automatic run_idle(input int mode, input int budget);
        bit idle;
        rdy_mode = mode;
        cyc      = 0;
        idle     = 1'b0;
        for (int i = 0; i < budget && !idle; i++) begin
            step();
            idle = (src[0].size() == 0) && (src[1].size() == 0) && (occ[0] == 0) && (occ[1] == 0);
        end
        chk("drain_done", 64'(idle), 64'(1));
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            s_vld[d]  = 1'b0;
            s_last[d] = 1'b0;
            s_dat[d]  = '0;
            m_rdy[d]  = 1'b0;
        end
        do_reset();

        // Short packets pass untouched; MAX=1 instance cuts A,B,C down to A
        add_pkt(0, 1, 32'h100);
        add_pkt(0, 3, 32'h200);
        add_pkt(0, 4, 32'h300);
        add_pkt(1, 3, 32'h0A0);
        run_idle(0, 200);
        chk("pkt_a_short", 64'(o_pkt[0]), 64'(3));
        chk("trunc_a_short", 64'(o_trc[0]), 64'(0));
        chk("pkt_b_abc", 64'(o_pkt[1]), 64'(1));
        chk("trunc_b_abc", 64'(o_trc[1]), 64'(1));

        // 7-beat packet truncated to 0..3, then 10,11; MAX=1 pkt_count saturates
        add_pkt(0, 7, 32'd0);
        add_pkt(0, 2, 32'd10);
        for (int i = 0; i < 5; i++) add_pkt(1, 1, 32'h500 + 32'(i));
        run_idle(0, 200);
        chk("pkt_a_trunc", 64'(o_pkt[0]), 64'(5));
        chk("trunc_a_trunc", 64'(o_trc[0]), 64'(1));
        chk("pkt_b_sat", 64'(o_pkt[1]), 64'(3));

        // Random packets, random valid gaps, 50% output backpressure
        rnd_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            add_pkt(0, $urandom_range(1, 9), $urandom);
            add_pkt(1, $urandom_range(1, 4), $urandom);
        end
        run_idle(1, 3000);
        rnd_valid = 1'b0;

        // Reach DROP with the skid register full, then reset mid-packet
        add_pkt(0, 7, 32'h700);
        rdy_mode  = 2;
        rdy_until = 3;
        cyc       = 0;
        repeat (5) step();
        chk("drop_skid_full_rdy", 64'(o_srdy[0]), 64'(1));
        chk("drop_skid_full_occ", 64'(occ[0]), 64'(2));
        do_reset();

        add_pkt(0, 3, 32'h800);
        for (int i = 0; i < 5; i++) add_pkt(1, 1, 32'h900 + 32'(i));
        run_idle(0, 200);
        chk("pkt_a_post_rst", 64'(o_pkt[0]), 64'(1));
        chk("trunc_a_post_rst", 64'(o_trc[0]), 64'(0));
        chk("pkt_b_post_rst_sat", 64'(o_pkt[1]), 64'(3));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
